bus_timer: RTL and testbench
============================

Name: bus_timer

Overview:
- Memory-mapped 32-bit timer peripheral on the CPU data bus, directly downstream of the datapath's data bus control unit.
- Decodes its own address window and executes register reads and writes.
- Drives one active-low IRQ line that feeds one bit of the CPU irq_sources vector.
- Provides the periodic and one-shot tick used by firmware ISRs.

Parameters:
- BASE_ADDR, 32'h8000_0100: window base; the window is 32 bytes and BASE_ADDR[4:0] must be 0.
- PRESCALE_WIDTH, 8: width of the prescaler field and of the prescaler counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- data_bus_data  inout  32  shared data bus; the block drives it only during its own read cycles, otherwise high-Z.
- data_bus_addr  input  32  byte address from the CPU.
- data_bus_mode  input  2  bus mode: 00 idle, 01 read, 10 write, 11 reserved (treated as idle).
- irq_n  output  1  active-low interrupt request.
- capture_in  input  1  external capture strobe; present only with BUS_TIMER_CAPTURE_EN.

Behaviour:
- Hit condition: data_bus_addr[31:5] == BASE_ADDR[31:5]. Offset is addr[4:2]; addr[1:0] is ignored.
- Register map:
  - +0x00 CTRL, RW: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN, bits[8+PRESCALE_WIDTH-1:8] PRESC. Other bits read 0.
  - +0x04 COUNT, RW.
  - +0x08 COMPARE, RW.
  - +0x0C STATUS: bit0 MATCH_PEND, write-1-to-clear; writing 0 has no effect.
  - +0x10 CAPTURE, RO.
  - All other offsets read 0; writes to them are ignored.
- Reads:
  - Combinational, zero wait states. The CPU asserts read mode only in the second cycle of a stalled LW, so data must be valid in that same cycle.
  - data_bus_data is driven with the register value while mode==01 and the address hits, otherwise 'z'.
  - Reads have no side effects.
- Writes: take effect on the clk edge at which mode==10 and the address hits. The full 32-bit word is written; there are no byte enables.
- Prescaler:
  - While EN=1, presc_cnt increments each clk.
  - When presc_cnt == PRESC, a tick is generated and presc_cnt returns to 0. Ticks therefore occur every PRESC+1 cycles; PRESC=0 gives a tick every cycle.
  - presc_cnt clears on any CTRL write and whenever EN=0.
- Counting:
  - On a tick, COUNT increments by 1. It wraps from 32'hFFFF_FFFF to 0 with no flag.
  - Match condition: tick AND COUNT == COMPARE, using the value before the increment.
  - On match, MATCH_PEND is set.
  - If PERIODIC=1 on match, COUNT loads 0 instead of incrementing.
  - If PERIODIC=0 on match, COUNT increments and EN clears (one-shot).
- irq_n = ~(MATCH_PEND & IRQ_EN). It is derived only from flops, so it is glitch-free. It stays low until software clears MATCH_PEND or clears IRQ_EN.
- Simultaneous events:
  - A COUNT write in the same cycle as a tick: the write wins, and that tick's match is suppressed.
  - A STATUS W1C in the same cycle as a new match: the set wins and MATCH_PEND stays 1.
  - A CTRL write in the same cycle as a one-shot match: the written EN wins.
- Reset:
  - CTRL, COUNT, COMPARE, STATUS, CAPTURE and presc_cnt all go to 0.
  - irq_n goes to 1; the bus is high-Z.
  - Reset mid-count aborts the count with no residual pending state.
- The block never drives the bus when mode is 00 or 11, or on a write cycle.

Optional Feature:
- Macro: BUS_TIMER_CAPTURE_EN.
- When defined:
  - The capture_in port exists and goes through a 2-flop synchronizer.
  - On a synchronized rising edge, CAPTURE <= COUNT and STATUS bit1 CAP_PEND is set (write-1-to-clear).
  - irq_n = ~((MATCH_PEND | CAP_PEND) & IRQ_EN).
  - If a capture edge coincides with a COUNT update, CAPTURE takes the pre-update value.
- When undefined:
  - The port is absent.
  - CAPTURE and STATUS bit1 read 0.
  - irq_n depends on MATCH_PEND only.

Test Plan:
- Reset state: after reset, read each of 0x8000_0100..0x8000_0110 -> all read 0, irq_n=1. With mode=00 or on a non-hit address, data_bus_data is 'z'.
- Periodic tick: COMPARE=4, CTRL=0x0000_0007 (PRESC=0) -> MATCH_PEND sets on the 5th tick after enable, COUNT returns to 0, irq_n goes low. W1C STATUS=1 -> irq_n=1. The next match follows 5 cycles later.
- Prescaler plus one-shot: PRESC=3, COMPARE=2, CTRL=0x0000_0305 -> match after 12 cycles, EN reads 0 afterwards, COUNT=3 and stays frozen.
- Conflicts:
  - W1C to STATUS in the match cycle -> MATCH_PEND remains 1.
  - COUNT write of 0x10 coinciding with a tick -> COUNT=0x10 and no match.
- Wrap: COUNT=0xFFFF_FFFF, COMPARE=5, EN=1, PRESC=0 -> COUNT reads 0 next cycle, and the match occurs 6 cycles later.
- Capture (with BUS_TIMER_CAPTURE_EN): pulse capture_in while COUNT is running -> CAPTURE equals COUNT 2-3 cycles after the edge, CAP_PEND=1, irq_n=0 when IRQ_EN=1.

Source files
------------

// File: rtl/bus_timer_if.sv
// Address/mode/IRQ signals between the CPU data bus controller and bus_timer.
// The shared tri-state data lines are wired as a plain inout port on the timer itself.
interface bus_timer_if;
    logic [31:0] data_bus_addr;
    logic [1:0]  data_bus_mode;
    logic        irq_n;

    modport master (output data_bus_addr, output data_bus_mode, input irq_n);
    modport slave  (input data_bus_addr, input data_bus_mode, output irq_n);
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit timer: prescaler, compare match (periodic/one-shot), active-low IRQ.
// Define BUS_TIMER_CAPTURE_EN to add the synchronized external capture unit.
module bus_timer #(
    parameter logic [31:0] BASE_ADDR      = 32'h8000_0100,
    parameter int          PRESCALE_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [31:0] data_bus_data,
    bus_timer_if.slave  bus
`ifdef BUS_TIMER_CAPTURE_EN
    ,
    input  logic        capture_in
`endif
);

    localparam logic [1:0] MODE_READ   = 2'b01;
    localparam logic [1:0] MODE_WRITE  = 2'b10;
    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_COUNT   = 3'd1;
    localparam logic [2:0] OFF_COMPARE = 3'd2;
    localparam logic [2:0] OFF_STATUS  = 3'd3;
    localparam logic [2:0] OFF_CAPTURE = 3'd4;

    logic                      hit, rd_en, wr_en;
    logic [2:0]                off;
    logic [31:0]               wdata, rdata;
    logic                      wr_ctrl, wr_count, wr_compare, wr_status;
    logic                      tick, match;
    logic                      unused_addr_lsb;

    logic                      en_q, en_d;
    logic                      periodic_q, irq_en_q;
    logic [PRESCALE_WIDTH-1:0] presc_q;
    logic [PRESCALE_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
    logic [31:0]               count_q, count_d;
    logic [31:0]               compare_q;
    logic                      match_pend_q, match_pend_d;

    logic [31:0]               capture_val;
    logic                      cap_pend;
    logic                      irq_pend;

    assign hit             = bus.data_bus_addr[31:5] == BASE_ADDR[31:5];
    assign off             = bus.data_bus_addr[4:2];
    assign unused_addr_lsb = ^bus.data_bus_addr[1:0];
    assign rd_en           = hit && (bus.data_bus_mode == MODE_READ);
    assign wr_en           = hit && (bus.data_bus_mode == MODE_WRITE);
    assign wdata           = data_bus_data;

    assign wr_ctrl    = wr_en && (off == OFF_CTRL);
    assign wr_count   = wr_en && (off == OFF_COUNT);
    assign wr_compare = wr_en && (off == OFF_COMPARE);
    assign wr_status  = wr_en && (off == OFF_STATUS);

    // A software COUNT write in the tick cycle overrides the counter and cancels that match.
    assign tick  = en_q && (presc_cnt_q == presc_q);
    assign match = tick && !wr_count && (count_q == compare_q);

    always_comb begin
        presc_cnt_d = presc_cnt_q + 1'b1;
        if (wr_ctrl || !en_q || tick) begin
            presc_cnt_d = '0;
        end

        count_d = count_q;
        if (wr_count) begin
            count_d = wdata;
        end else if (match && periodic_q) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_q + 32'd1;
        end

        en_d = en_q;
        if (wr_ctrl) begin
            en_d = wdata[0];
        end else if (match && !periodic_q) begin
            en_d = 1'b0;
        end

        match_pend_d = match_pend_q;
        if (match) begin
            match_pend_d = 1'b1;
        end else if (wr_status && wdata[0]) begin
            match_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q         <= 1'b0;
            periodic_q   <= 1'b0;
            irq_en_q     <= 1'b0;
            presc_q      <= '0;
            presc_cnt_q  <= '0;
            count_q      <= '0;
            compare_q    <= '0;
            match_pend_q <= 1'b0;
        end else begin
            en_q         <= en_d;
            presc_cnt_q  <= presc_cnt_d;
            count_q      <= count_d;
            match_pend_q <= match_pend_d;
            if (wr_ctrl) begin
                periodic_q <= wdata[1];
                irq_en_q   <= wdata[2];
                presc_q    <= wdata[8 +: PRESCALE_WIDTH];
            end
            if (wr_compare) begin
                compare_q <= wdata;
            end
        end
    end

`ifdef BUS_TIMER_CAPTURE_EN
    logic [1:0]  cap_sync_q;
    logic        cap_prev_q;
    logic        cap_rise;
    logic [31:0] capture_q;
    logic        cap_pend_q, cap_pend_d;

    assign cap_rise = cap_sync_q[1] && !cap_prev_q;

    always_comb begin
        cap_pend_d = cap_pend_q;
        if (cap_rise) begin
            cap_pend_d = 1'b1;
        end else if (wr_status && wdata[1]) begin
            cap_pend_d = 1'b0;
        end
    end

    // count_q is the pre-update value, so a coinciding COUNT change is not captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_sync_q <= '0;
            cap_prev_q <= 1'b0;
            capture_q  <= '0;
            cap_pend_q <= 1'b0;
        end else begin
            cap_sync_q <= {cap_sync_q[0], capture_in};
            cap_prev_q <= cap_sync_q[1];
            cap_pend_q <= cap_pend_d;
            if (cap_rise) begin
                capture_q <= count_q;
            end
        end
    end

    assign capture_val = capture_q;
    assign cap_pend    = cap_pend_q;
    assign irq_pend    = match_pend_q | cap_pend_q;
`else
    assign capture_val = '0;
    assign cap_pend    = 1'b0;
    assign irq_pend    = match_pend_q;
`endif

    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL: begin
                rdata[0]                    = en_q;
                rdata[1]                    = periodic_q;
                rdata[2]                    = irq_en_q;
                rdata[8 +: PRESCALE_WIDTH]  = presc_q;
            end
            OFF_COUNT:   rdata = count_q;
            OFF_COMPARE: rdata = compare_q;
            OFF_STATUS:  rdata[1:0] = {cap_pend, match_pend_q};
            OFF_CAPTURE: rdata = capture_val;
            default:     rdata = '0;
        endcase
    end

    assign data_bus_data = rd_en ? rdata : 'z;
    assign bus.irq_n     = ~(irq_pend & irq_en_q);

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: directed scenarios plus randomized bus traffic
// checked against a cycle-level behavioural model of the register file and timer.
module tb_bus_timer;

    localparam logic [31:0] BASE = 32'h8000_0100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_timer_if bus ();
    wire  [31:0] data_bus_data;
    logic        tb_drv_en;
    logic [31:0] tb_wdata;
    assign data_bus_data = tb_drv_en ? tb_wdata : 'z;

`ifdef BUS_TIMER_CAPTURE_EN
    logic capture_in = 1'b0;
`endif

    bus_timer #(.BASE_ADDR(BASE), .PRESCALE_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .data_bus_data (data_bus_data),
        .bus           (bus)
`ifdef BUS_TIMER_CAPTURE_EN
        ,
        .capture_in    (capture_in)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: ticks fall where the enabled-cycle phase hits PRESC modulo PRESC+1.
    logic        m_en, m_per, m_ie, m_pend, m_cpend;
    logic [7:0]  m_presc;
    logic [31:0] m_cnt, m_cmp, m_capv;
    int          m_phase;

    task automatic m_reset();
        m_en = 0; m_per = 0; m_ie = 0; m_pend = 0; m_cpend = 0;
        m_presc = 0; m_cnt = 0; m_cmp = 0; m_capv = 0; m_phase = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:5] != BASE[31:5]) return 32'h0;
        case (a[4:2])
            3'd0:    return {16'h0, m_presc, 5'h0, m_ie, m_per, m_en};
            3'd1:    return m_cnt;
            3'd2:    return m_cmp;
            3'd3:    return {30'h0, m_cpend, m_pend};
            3'd4:    return m_capv;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_irq_n();
        return !((m_pend || m_cpend) && m_ie);
    endfunction

    task automatic m_step(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] wd);
        logic       wr, tk, mt;
        logic [2:0] o;
        wr = (a[31:5] == BASE[31:5]) && (mode == 2'b10);
        o  = a[4:2];
        tk = m_en && ((m_phase % (int'(m_presc) + 1)) == int'(m_presc));
        mt = tk && !(wr && o == 3'd1) && (m_cnt == m_cmp);
        if (wr && o == 3'd1) m_cnt = wd;
        else if (tk)         m_cnt = (mt && m_per) ? 32'h0 : m_cnt + 32'd1;
        if (wr && o == 3'd3) begin
            if (wd[0]) m_pend = 0;
            if (wd[1]) m_cpend = 0;
        end
        if (mt) m_pend = 1;
        if (m_en) m_phase++;
        if (mt && !m_per) m_en = 0;
        if (wr && o == 3'd0) begin
            m_en = wd[0]; m_per = wd[1]; m_ie = wd[2]; m_presc = wd[15:8];
        end
        if (wr && o == 3'd2) m_cmp = wd;
        if (!m_en || (wr && o == 3'd0)) m_phase = 0;
    endtask

    // Results of the most recent bus cycle.
    logic [31:0] r_act, r_exp;
    logic        i_act, i_exp;

    // The bench holds the bus at its own value whenever the DUT must not drive, so any
    // stray DUT drive shows up as a corrupted read-back.
    task automatic bus_op(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus.data_bus_mode = mode;
        bus.data_bus_addr = a;
        if (mode == 2'b01 && a[31:5] == BASE[31:5]) begin
            tb_drv_en = 1'b0;
        end else begin
            tb_drv_en = 1'b1;
            tb_wdata  = (mode == 2'b10) ? wd : 32'h0;
        end
        #1;
        r_act = data_bus_data;
        i_act = bus.irq_n;
        r_exp = (mode == 2'b01) ? m_read(a) : ((mode == 2'b10) ? wd : 32'h0);
        i_exp = m_irq_n();
        @(posedge clk);
        m_step(mode, a, wd);
    endtask

    task automatic wr(input logic [2:0] o, input logic [31:0] d);
        bus_op(2'b10, BASE + {27'h0, o, 2'b00}, d);
    endtask

    task automatic rd(input logic [2:0] o);
        bus_op(2'b01, BASE + {27'h0, o, 2'b00}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.data_bus_mode = 2'b00;
        tb_drv_en = 1'b1;
        tb_wdata  = 32'h0;
        repeat (2) @(posedge clk);
        m_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rd(3'(i));
            n_total++;
            if (r_act !== 32'h0) $display("FAIL reset_rd[%0d]: got %h want 00000000", i, r_act);
            else n_pass++;
            n_total++;
            if (i_act !== 1'b1) $display("FAIL reset_irq[%0d]: got %b want 1", i, i_act);
            else n_pass++;
        end
        wr(3'd1, 32'h0000_00AA);
        bus_op(2'b00, BASE + 32'h4, 32'h0);
        n_total++;
        if (r_act !== 32'h0) $display("FAIL idle_nodrive: got %h want 00000000", r_act);
        else n_pass++;
        bus_op(2'b11, BASE + 32'h4, 32'h0);
        n_total++;
        if (r_act !== 32'h0) $display("FAIL rsvd_nodrive: got %h want 00000000", r_act);
        else n_pass++;
        bus_op(2'b01, 32'h8000_0204, 32'h0);
        n_total++;
        if (r_act !== 32'h0) $display("FAIL miss_nodrive: got %h want 00000000", r_act);
        else n_pass++;
    endtask

    task automatic test_periodic();
        do_reset();
        wr(3'd2, 32'd4);
        wr(3'd0, 32'h0000_0007);
        for (int i = 0; i < 5; i++) begin
            rd(3'd1);
            n_total++;
            if (r_act !== 32'(i)) $display("FAIL periodic_count[%0d]: got %h want %h", i, r_act, 32'(i));
            else n_pass++;
        end
        rd(3'd3);
        n_total++;
        if (r_act !== 32'h1 || i_act !== 1'b0) $display("FAIL periodic_match: status %h irq %b want 1/0", r_act, i_act);
        else n_pass++;
        wr(3'd3, 32'h1);
        for (int i = 0; i < 4; i++) begin
            rd(3'd3);
            n_total++;
            if (r_act !== ((i == 3) ? 32'h1 : 32'h0) || i_act !== (i != 3))
                $display("FAIL periodic_rematch[%0d]: status %h irq %b", i, r_act, i_act);
            else n_pass++;
        end
    endtask

    task automatic test_oneshot();
        do_reset();
        wr(3'd2, 32'd2);
        wr(3'd0, 32'h0000_0305);
        for (int i = 0; i < 13; i++) begin
            rd(3'd3);
            n_total++;
            if (r_act !== ((i == 12) ? 32'h1 : 32'h0)) $display("FAIL oneshot_status[%0d]: got %h", i, r_act);
            else n_pass++;
        end
        n_total++;
        if (i_act !== 1'b0) $display("FAIL oneshot_irq: got %b want 0", i_act);
        else n_pass++;
        rd(3'd0);
        n_total++;
        if (r_act !== 32'h0000_0304) $display("FAIL oneshot_ctrl: got %h want 00000304", r_act);
        else n_pass++;
        repeat (5) bus_op(2'b00, BASE, 32'h0);
        rd(3'd1);
        n_total++;
        if (r_act !== 32'd3) $display("FAIL oneshot_frozen: got %h want 00000003", r_act);
        else n_pass++;
    endtask

    task automatic test_conflicts();
        do_reset();
        wr(3'd2, 32'd2);
        wr(3'd0, 32'h0000_0005);
        rd(3'd1);
        rd(3'd1);
        wr(3'd3, 32'h1);
        rd(3'd3);
        n_total++;
        if (r_act !== 32'h1 || i_act !== 1'b0) $display("FAIL w1c_vs_match: status %h irq %b want 1/0", r_act, i_act);
        else n_pass++;

        do_reset();
        wr(3'd2, 32'd2);
        wr(3'd0, 32'h0000_0007);
        rd(3'd1);
        rd(3'd1);
        wr(3'd1, 32'h10);
        rd(3'd1);
        n_total++;
        if (r_act !== 32'h10) $display("FAIL count_wr_vs_tick: got %h want 00000010", r_act);
        else n_pass++;
        rd(3'd3);
        n_total++;
        if (r_act !== 32'h0) $display("FAIL count_wr_nomatch: got %h want 00000000", r_act);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd2, 32'd5);
        wr(3'd0, 32'h0000_0001);
        rd(3'd1);
        n_total++;
        if (r_act !== 32'hFFFF_FFFF) $display("FAIL wrap_pre: got %h want ffffffff", r_act);
        else n_pass++;
        rd(3'd1);
        n_total++;
        if (r_act !== 32'h0) $display("FAIL wrap_zero: got %h want 00000000", r_act);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            rd(3'd3);
            n_total++;
            if (r_act !== ((i == 5) ? 32'h1 : 32'h0)) $display("FAIL wrap_match[%0d]: got %h", i, r_act);
            else n_pass++;
        end
        rd(3'd1);
        n_total++;
        if (r_act !== 32'd6) $display("FAIL wrap_final: got %h want 00000006", r_act);
        else n_pass++;
    endtask

    task automatic test_reset_midcount();
        do_reset();
        wr(3'd2, 32'd1);
        wr(3'd0, 32'h0000_0007);
        repeat (4) bus_op(2'b00, BASE, 32'h0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rd(3'(i));
            n_total++;
            if (r_act !== 32'h0 || i_act !== 1'b1) $display("FAIL midreset[%0d]: got %h irq %b", i, r_act, i_act);
            else n_pass++;
        end
    endtask

`ifdef BUS_TIMER_CAPTURE_EN
    task automatic test_capture();
        do_reset();
        wr(3'd1, 32'h0000_1234);
        wr(3'd0, 32'h0000_0004);
        capture_in = 1'b1;
        repeat (2) bus_op(2'b00, BASE, 32'h0);
        capture_in = 1'b0;
        repeat (3) bus_op(2'b00, BASE, 32'h0);
        m_capv = 32'h0000_1234;
        m_cpend = 1'b1;
        rd(3'd4);
        n_total++;
        if (r_act !== 32'h0000_1234) $display("FAIL capture_val: got %h want 00001234", r_act);
        else n_pass++;
        rd(3'd3);
        n_total++;
        if (r_act !== 32'h2 || i_act !== 1'b0) $display("FAIL capture_pend: status %h irq %b want 2/0", r_act, i_act);
        else n_pass++;
        wr(3'd3, 32'h2);
        rd(3'd3);
        n_total++;
        if (r_act !== 32'h0 || i_act !== 1'b1) $display("FAIL capture_clear: status %h irq %b want 0/1", r_act, i_act);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic [31:0] a, d;
        logic [1:0]  m;
        int          k;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 9);
            a = BASE + {27'h0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            d = $urandom;
            m = 2'b01;
            case (k)
                3: begin
                    m = 2'b10; a = BASE;
                    d[15:8] = 8'($urandom_range(0, 3));
                    d[0] = ($urandom_range(0, 3) != 0);
                end
                4: begin
                    m = 2'b10; a = BASE + 32'h4;
                    d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 12));
                end
                5: begin m = 2'b10; a = BASE + 32'h8; d = 32'($urandom_range(0, 12)); end
                6: begin m = 2'b10; a = BASE + 32'hC; end
                7: begin m = 2'b10; a = BASE + {27'h0, 3'($urandom_range(4, 7)), 2'b00}; end
                8: m = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
                9: begin
                    m = 2'($urandom_range(0, 3));
                    a = BASE ^ (32'h1 << $urandom_range(5, 31));
                end
                default: m = 2'b01;
            endcase
            bus_op(m, a, d);
            n_total++;
            if (r_act !== r_exp) $display("FAIL rand_bus[%0d]: mode %b addr %h got %h want %h", i, m, a, r_act, r_exp);
            else n_pass++;
            n_total++;
            if (i_act !== i_exp) $display("FAIL rand_irq[%0d]: got %b want %b", i, i_act, i_exp);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        tb_drv_en = 1'b1;
        tb_wdata = 32'h0;
        bus.data_bus_addr = 32'h0;
        bus.data_bus_mode = 2'b00;
        m_reset();
        test_reset();
        test_periodic();
        test_oneshot();
        test_conflicts();
        test_wrap();
        test_reset_midcount();
`ifdef BUS_TIMER_CAPTURE_EN
        test_capture();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
